// File: rtl/dff_response_checker.sv
// Response checker for a one-cycle delay DUT: predicts q as d registered once,
// counts mismatches over a fixed compare window and latches a pass/fail verdict.
module dff_response_checker #(
  parameter int WIDTH         = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_CHECKS    = 64,
  parameter int MAX_ERRORS    = 15,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] exp_q,
  output logic             checking,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic             done,
  output logic             pass,
  output logic             fail
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0]   chk_cnt_q, chk_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0]   exp_q_q, exp_q_d;
  logic               checking_q, checking_d;
  logic               mismatch_q, mismatch_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic               cmp_miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= {CNT_W{1'b0}};
      chk_cnt_q    <= {CNT_W{1'b0}};
      err_cnt_q    <= {CNT_W{1'b0}};
      exp_q_q      <= {WIDTH{1'b0}};
      checking_q   <= 1'b0;
      mismatch_q   <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      chk_cnt_q    <= chk_cnt_d;
      err_cnt_q    <= err_cnt_d;
      exp_q_q      <= exp_q_d;
      checking_q   <= checking_d;
      mismatch_q   <= mismatch_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    chk_cnt_d    = chk_cnt_q;
    err_cnt_d    = err_cnt_q;
    cmp_miss     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d      = ST_SETTLE;
        settle_cnt_d = CNT_W'(1);
      end
      ST_SETTLE: begin
        settle_cnt_d = settle_cnt_q + CNT_W'(1);
        if (settle_cnt_q == CNT_W'(SETTLE_CYCLES)) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_CHECK: begin
        // The compare on the exiting edge still counts toward the verdict.
        cmp_miss  = (q != exp_q_q);
        chk_cnt_d = chk_cnt_q + CNT_W'(1);
        if (cmp_miss && (err_cnt_q < CNT_W'(MAX_ERRORS))) begin
          err_cnt_d = err_cnt_q + CNT_W'(1);
        end else begin
          err_cnt_d = err_cnt_q;
        end
        if ((chk_cnt_d == CNT_W'(NUM_CHECKS)) || (err_cnt_d == CNT_W'(MAX_ERRORS))) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    exp_q_d    = d;
    checking_d = (state_d == ST_CHECK);
    mismatch_d = cmp_miss;
    done_d     = (state_d == ST_DONE);
    pass_d     = done_d && (err_cnt_d == {CNT_W{1'b0}});
    fail_d     = done_d && (err_cnt_d != {CNT_W{1'b0}});
  end

  assign exp_q     = exp_q_q;
  assign checking  = checking_q;
  assign mismatch  = mismatch_q;
  assign err_count = err_cnt_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_dff_response_checker.sv
// Scoreboard bench: stimulus pushes the expected post-edge output record,
// a monitor pops and compares one record per clock.
module tb_dff_response_checker;

  localparam int S    = 2;
  localparam int N    = 64;
  localparam int MAXE = 15;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          d   = 1'b0;
  logic          q   = 1'b0;
  logic          exp_q;
  logic          checking;
  logic          mismatch;
  logic [CW-1:0] err_count;
  logic          done;
  logic          pass;
  logic          fail;

  typedef struct packed {
    logic          eq;
    logic          chk;
    logic          mm;
    logic [CW-1:0] ec;
    logic          dn;
    logic          ps;
    logic          fl;
  } rec_t;

  rec_t exp_fifo[$];
  rec_t mon_e;
  rec_t mon_a;
  int   checks = 0;
  int   errors = 0;

  dff_response_checker #(
    .WIDTH(1), .SETTLE_CYCLES(S), .NUM_CHECKS(N), .MAX_ERRORS(MAXE), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .d(d), .q(q), .exp_q(exp_q), .checking(checking),
    .mismatch(mismatch), .err_count(err_count), .done(done), .pass(pass), .fail(fail)
  );

  always #5 clk = ~clk;

  function automatic rec_t sample();
    rec_t r;
    r = '{eq: exp_q, chk: checking, mm: mismatch, ec: err_count, dn: done, ps: pass, fl: fail};
    return r;
  endfunction

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (exp_fifo.size() > 0) begin
        mon_e = exp_fifo.pop_front();
        mon_a = sample();
        checks++;
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL cycle_record t=%0t actual eq/chk/mm/ec/dn/ps/fl=%b/%b/%b/%0d/%b/%b/%b required=%b/%b/%b/%0d/%b/%b/%b",
                   $time, mon_a.eq, mon_a.chk, mon_a.mm, mon_a.ec, mon_a.dn, mon_a.ps, mon_a.fl,
                   mon_e.eq, mon_e.chk, mon_e.mm, mon_e.ec, mon_e.dn, mon_e.ps, mon_e.fl);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    rec_t a;
    a = sample();
    checks++;
    if (a !== '0) begin
      errors++;
      $display("FAIL %s actual=%h required=0", name, a);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("async_reset");
  endtask

  // mode 0 clean, 1 flip q at compare 10, 2 stuck q=0 with toggling d, 3 bad q during settle
  task automatic run(input int mode, input int n, input int abort_k);
    int   k;
    int   errs;
    logic prev_d, dv, qv, mm, m_done, m_chk;
    rec_t r;
    prev_d = 1'b0;
    errs   = 0;
    m_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= n; e++) begin
      k = e - (S + 1);
      case (mode)
        1: begin dv = 1'($urandom_range(0, 1)); qv = prev_d ^ (k == 10); end
        2: begin dv = ((e + 1) % 2 == 1); qv = 1'b0; end
        3: begin dv = 1'($urandom_range(0, 1)); qv = (k <= 0) ? ~prev_d : prev_d; end
        default: begin dv = 1'($urandom_range(0, 1)); qv = prev_d; end
      endcase
      d = dv;
      q = qv;
      mm    = 1'b0;
      m_chk = 1'b0;
      if (!m_done) begin
        if (k >= 1) begin
          mm = (qv != prev_d);
          if (mm && errs < MAXE) errs++;
          if (k == N || errs == MAXE) m_done = 1'b1;
          m_chk = !m_done;
        end else begin
          m_chk = (k == 0);
        end
      end
      r = '{eq: dv, chk: m_chk, mm: mm, ec: CW'(errs), dn: m_done,
            ps: m_done && errs == 0, fl: m_done && errs != 0};
      exp_fifo.push_back(r);
      prev_d = dv;
      @(negedge clk);
      if (abort_k > 0 && k == abort_k) begin
        rst = 1'b1;
        #1;
        check_zero("abort_reset");
        return;
      end
    end
  endtask

  initial begin : stim
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      d = 1'($urandom_range(0, 1));
      q = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check_zero("reset_hold");
    end
    run(0, S + N + 4, 0);
    do_reset();
    run(1, S + N + 4, 0);
    do_reset();
    run(2, S + 36, 0);
    do_reset();
    run(0, S + N + 4, 20);
    run(0, S + N + 4, 0);
    do_reset();
    run(3, S + N + 4, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_fifo.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d required=0", exp_fifo.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
